program_sequencer: RTL and testbench

//  Drives the 8-bit ALU datapath (control unit + ALU + result register) from a stored program.
//  It fetches 18-bit instructions from an internal program RAM and reads operands from a 4x8 register file.
//  It presents a/b/opcode to the datapath, then captures the result and carry into the register file and a flag.
//  A host loads the program and pulses start. The block runs to a halt instruction and reports done.

---
 rtl/program_sequencer_if.sv | 40 ++++
 rtl/program_sequencer.sv | 136 +++++++++++++
 tb/tb_program_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_sequencer_if.sv
// Bus between the program sequencer and its host/datapath side: program load
// port, run control, operand/result exchange with the ALU and the debug read.
interface program_sequencer_if #(
    parameter int PROG_DEPTH = 16
);
    localparam int AW = $clog2(PROG_DEPTH);

    // Program load and run control
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [17:0]   prog_wdata;
    logic          start;

    // Datapath exchange
    logic [7:0]    a;
    logic [7:0]    b;
    logic [2:0]    opcode;
    logic [7:0]    result_in;
    logic          carry_in;

    // Status and debug
    logic          busy;
    logic          done;
    logic          carry_flag;
    logic [AW-1:0] pc;
    logic [1:0]    dbg_sel;
    logic [7:0]    dbg_data;

    // Host/datapath side
    modport master (
        output prog_we, prog_addr, prog_wdata, start, result_in, carry_in, dbg_sel,
        input  a, b, opcode, busy, done, carry_flag, pc, dbg_data
    );

    // Sequencer side
    modport slave (
        input  prog_we, prog_addr, prog_wdata, start, result_in, carry_in, dbg_sel,
        output a, b, opcode, busy, done, carry_flag, pc, dbg_data
    );
endinterface

// File: rtl/program_sequencer.sv
// Stored-program sequencer for the 8-bit ALU datapath. Fetches 18-bit
// instructions from a host-loaded program RAM, presents operands from a 4x8
// register file to the datapath and writes the result/carry back.
// Instruction: [17] halt, [16] imm_sel, [15:13] opcode, [12:11] rd,
//              [10:9] ra, [8] reserved, [7:0] imm (imm[1:0] = rb when imm_sel=0).
// PROG_DEPTH must match the PROG_DEPTH of the connected interface.
module program_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int RESULT_LAT = 0
) (
    input logic                 clk,
    input logic                 rst,
    program_sequencer_if.slave  bus
);
    localparam int AW = $clog2(PROG_DEPTH);

    typedef enum logic [2:0] {
        s_idle,
        s_fetch,
        s_decode,
        s_exec,
        s_wait,
        s_wb,
        s_halt
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [17:0]   prog_ram [PROG_DEPTH];
    logic [17:0]   instr;
    logic [AW-1:0] pc_q;
    logic [7:0]    regs [4];
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [2:0]    opcode_q;
    logic          carry_q;

    // Decoded fields of the current instruction
    logic          instr_halt;
    logic          instr_imm_sel;
    logic [2:0]    instr_op;
    logic [1:0]    instr_rd;
    logic [1:0]    instr_ra;
    logic [1:0]    instr_rb;
    logic [7:0]    instr_imm;
    logic          unused_reserved;

    assign instr_halt      = instr[17];
    assign instr_imm_sel   = instr[16];
    assign instr_op        = instr[15:13];
    assign instr_rd        = instr[12:11];
    assign instr_ra        = instr[10:9];
    assign unused_reserved = instr[8];
    assign instr_imm       = instr[7:0];
    assign instr_rb        = instr[1:0];

    // Host may load the RAM and start a run only while nothing is executing
    logic loadable;
    assign loadable = (state == s_idle) || (state == s_halt);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= s_idle;
        else     state <= state_nx;
    end

    // Next-state logic: fetch, decode, execute, optional wait, writeback
    always_comb begin
        // NOTE: default assigned first so every path drives state_nx; a missing branch would infer a latch.
        state_nx = state;
        case (state)
            s_idle, s_halt: if (bus.start) state_nx = s_fetch;
            s_fetch:        state_nx = s_decode;
            s_decode:       state_nx = instr_halt ? s_halt : s_exec;
            s_exec:         state_nx = (RESULT_LAT != 0) ? s_wait : s_wb;
            s_wait:         state_nx = s_wb;
            s_wb:           state_nx = s_fetch;
            default:        state_nx = s_idle;
        endcase
    end

    // Program RAM write port
    // NOTE: the RAM deliberately has no reset; its contents survive rst and it can map to plain memory.
    always_ff @(posedge clk) begin
        if (bus.prog_we && loadable) prog_ram[bus.prog_addr] <= bus.prog_wdata;
    end

    // Instruction register, program counter, operand and carry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= '0;
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates, so decode reads the register file as it stood before this edge.
            case (state)
                s_idle, s_halt: if (bus.start) pc_q <= '0;
                s_fetch:        instr <= prog_ram[pc_q];
                s_decode: begin
                    if (!instr_halt) begin
                        a_q      <= regs[instr_ra];
                        b_q      <= instr_imm_sel ? instr_imm : regs[instr_rb];
                        opcode_q <= instr_op;
                    end
                end
                s_wb: begin
                    carry_q <= bus.carry_in;
                    pc_q    <= pc_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Register file writeback of the datapath result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (state == s_wb) begin
            regs[instr_rd] <= bus.result_in;
        end
    end

    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.opcode     = opcode_q;
    assign bus.carry_flag = carry_q;
    assign bus.pc         = pc_q;
    assign bus.busy       = !loadable;
    assign bus.done       = (state == s_halt);
    assign bus.dbg_data   = regs[bus.dbg_sel];
endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: two instances (16-deep/zero-latency with a
// combinational ALU, 4-deep/one-wait with a registered ALU) run against an
// instruction-level model that is compared on every falling edge.
module tb_program_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    program_sequencer_if #(.PROG_DEPTH(16)) bus_a ();
    program_sequencer_if #(.PROG_DEPTH(4))  bus_b ();

    program_sequencer #(.PROG_DEPTH(16), .RESULT_LAT(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    program_sequencer #(.PROG_DEPTH(4),  .RESULT_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, 5 not a, 6 shl a, 7 pass b
    function automatic logic [8:0] alu(logic [7:0] x, logic [7:0] y, logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, x} + {1'b0, y};
            3'd1:    return {1'b0, x} - {1'b0, y};
            3'd2:    return {1'b0, x & y};
            3'd3:    return {1'b0, x | y};
            3'd4:    return {1'b0, x ^ y};
            3'd5:    return {1'b0, ~x};
            3'd6:    return {x, 1'b0};
            default: return {1'b0, y};
        endcase
    endfunction

    // Datapath A is combinational, datapath B has a registered result
    assign {bus_a.carry_in, bus_a.result_in} = alu(bus_a.a, bus_a.b, bus_a.opcode);
    always @(posedge clk) {bus_b.carry_in, bus_b.result_in} <= alu(bus_b.a, bus_b.b, bus_b.opcode);

    function automatic logic [17:0] enc(bit h, bit is, logic [2:0] op, logic [1:0] rd,
                                        logic [1:0] ra, logic [7:0] imm);
        return {h, is, op, rd, ra, 1'b0, imm};
    endfunction

    // Instruction-level model: k = cycles elapsed in the current instruction
    typedef struct packed {
        logic              busy;
        logic              done;
        logic              carry;
        logic [7:0]        a;
        logic [7:0]        b;
        logic [2:0]        op;
        logic [3:0][7:0]   regs;
        logic [15:0][17:0] ram;
        int                pc;
        int                k;
    } model_t;

    model_t ma;
    model_t mb;

    function automatic model_t mreset(model_t m);
        model_t n = m;
        n.busy = 1'b0; n.done = 1'b0; n.carry = 1'b0;
        n.a = '0; n.b = '0; n.op = '0; n.regs = '0; n.pc = 0; n.k = 0;
        return n;
    endfunction

    function automatic model_t mstep(model_t m, int depth, int lat, logic we, int addr,
                                     logic [17:0] wd, logic st);
        model_t n = m;
        logic [17:0] ins;
        logic [8:0] r;
        ins = m.ram[m.pc];
        if (!m.busy) begin
            if (we) n.ram[addr] = wd;
            if (st) begin n.busy = 1'b1; n.done = 1'b0; n.pc = 0; n.k = 0; end
        end else if (m.k == 1) begin
            if (ins[17]) begin
                n.busy = 1'b0; n.done = 1'b1;
            end else begin
                n.a  = m.regs[ins[10:9]];
                n.b  = ins[16] ? ins[7:0] : m.regs[ins[1:0]];
                n.op = ins[15:13];
                n.k  = 2;
            end
        end else if (m.k == 3 + lat) begin
            r = alu(m.a, m.b, m.op);
            n.regs[ins[12:11]] = r[7:0];
            n.carry = r[8];
            n.pc = (m.pc + 1) % depth;
            n.k = 0;
        end else begin
            n.k = m.k + 1;
        end
        return n;
    endfunction

    // Model advance, mirroring the asynchronous reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mreset(ma);
            mb <= mreset(mb);
        end else begin
            ma <= mstep(ma, 16, 0, bus_a.prog_we, int'(bus_a.prog_addr), bus_a.prog_wdata, bus_a.start);
            mb <= mstep(mb, 4, 1, bus_b.prog_we, int'(bus_b.prog_addr), bus_b.prog_wdata, bus_b.start);
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("a_busy",  bus_a.busy,       ma.busy);
            check("a_done",  bus_a.done,       ma.done);
            check("a_pc",    bus_a.pc,         ma.pc);
            check("a_carry", bus_a.carry_flag, ma.carry);
            check("a_opa",   bus_a.a,          ma.a);
            check("a_opb",   bus_a.b,          ma.b);
            check("a_op",    bus_a.opcode,     ma.op);
            check("a_dbg",   bus_a.dbg_data,   ma.regs[bus_a.dbg_sel]);
            check("b_busy",  bus_b.busy,       mb.busy);
            check("b_done",  bus_b.done,       mb.done);
            check("b_pc",    bus_b.pc,         mb.pc);
            check("b_carry", bus_b.carry_flag, mb.carry);
            check("b_opa",   bus_b.a,          mb.a);
            check("b_opb",   bus_b.b,          mb.b);
            check("b_op",    bus_b.opcode,     mb.op);
            check("b_dbg",   bus_b.dbg_data,   mb.regs[bus_b.dbg_sel]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus_a.dbg_sel = 2'($urandom_range(0, 3));
        bus_b.dbg_sel = 2'($urandom_range(0, 3));
    endtask

    task automatic load(int which, int addr, logic [17:0] w);
        if (which == 0) begin
            bus_a.prog_we = 1'b1; bus_a.prog_addr = 4'(addr); bus_a.prog_wdata = w;
        end else begin
            bus_b.prog_we = 1'b1; bus_b.prog_addr = 2'(addr); bus_b.prog_wdata = w;
        end
        tick();
        bus_a.prog_we = 1'b0;
        bus_b.prog_we = 1'b0;
    endtask

    task automatic pulse_start(int which);
        if (which == 0) bus_a.start = 1'b1;
        else            bus_b.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    function automatic logic is_done(int which);
        return (which == 0) ? bus_a.done : bus_b.done;
    endfunction

    task automatic wait_done(int which, int c0, int exp, string name);
        int c = c0;
        while (!is_done(which) && c < 200) begin
            tick();
            c++;
        end
        check(name, c, exp);
    endtask

    task automatic chk_reg(int which, int sel, logic [7:0] exp, string name);
        @(posedge clk);
        #2;
        bus_a.dbg_sel = 2'(sel);
        bus_b.dbg_sel = 2'(sel);
        #1;
        check(name, (which == 0) ? bus_a.dbg_data : bus_b.dbg_data, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        logic [31:0] rv;
        logic [17:0] w;
        int          which;

        rst = 1'b1;
        bus_a.prog_we = 1'b0; bus_a.prog_addr = '0; bus_a.prog_wdata = '0; bus_a.start = 1'b0; bus_a.dbg_sel = '0;
        bus_b.prog_we = 1'b0; bus_b.prog_addr = '0; bus_b.prog_wdata = '0; bus_b.start = 1'b0; bus_b.dbg_sel = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_busy_a", bus_a.busy, 0);
        check("rst_done_a", bus_a.done, 0);
        check("rst_pc_a",   bus_a.pc,   0);
        check("rst_busy_b", bus_b.busy, 0);
        for (int s = 0; s < 4; s++) begin
            chk_reg(0, s, 8'h00, "rst_reg_a");
            chk_reg(1, s, 8'h00, "rst_reg_b");
        end

        // Immediate add with carry out, then halt
        load(0, 0, enc(0, 1, 3'd0, 2'd0, 2'd0, 8'h05));
        load(0, 1, enc(0, 1, 3'd0, 2'd1, 2'd0, 8'hFF));
        load(0, 2, enc(1, 0, 3'd0, 2'd0, 2'd0, 8'h00));
        pulse_start(0);
        wait_done(0, 0, 10, "t2_cycles");
        check("t2_carry", bus_a.carry_flag, 1);
        chk_reg(0, 0, 8'h05, "t2_r0");
        chk_reg(0, 1, 8'h04, "t2_r1");

        // Register-register subtract; restart after halt; guarded load/start while busy
        load(0, 0, enc(0, 1, 3'd0, 2'd0, 2'd3, 8'h10));
        load(0, 1, enc(0, 1, 3'd0, 2'd1, 2'd3, 8'h03));
        load(0, 2, enc(0, 0, 3'd1, 2'd2, 2'd0, 8'h01));
        load(0, 3, enc(1, 0, 3'd0, 2'd0, 2'd0, 8'h00));
        pulse_start(0);
        check("t6_done_clr", bus_a.done, 0);
        check("t6_busy",     bus_a.busy, 1);
        check("t6_pc0",      bus_a.pc,   0);
        bus_a.dbg_sel = 2'd1;
        #1 check("t6_r1_kept", bus_a.dbg_data, 8'h04);
        tick();
        tick();
        bus_a.prog_we = 1'b1; bus_a.prog_addr = 4'd0; bus_a.prog_wdata = enc(1, 0, 3'd0, 2'd0, 2'd0, 8'h00);
        bus_a.start = 1'b1;
        tick();
        bus_a.prog_we = 1'b0; bus_a.start = 1'b0;
        wait_done(0, 3, 14, "t5_no_restart_cycles");
        check("t3_halt_pc", bus_a.pc, 3);
        check("t3_carry",   bus_a.carry_flag, 0);
        chk_reg(0, 2, 8'h0D, "t3_r2");
        pulse_start(0);
        wait_done(0, 0, 14, "t5_ram_kept_cycles");

        // Same subtract on the one-wait instance: 5 cycles per instruction
        load(1, 0, enc(0, 1, 3'd0, 2'd0, 2'd3, 8'h10));
        load(1, 1, enc(0, 1, 3'd0, 2'd1, 2'd3, 8'h03));
        load(1, 2, enc(0, 0, 3'd1, 2'd2, 2'd0, 8'h01));
        load(1, 3, enc(1, 0, 3'd0, 2'd0, 2'd0, 8'h00));
        pulse_start(1);
        wait_done(1, 0, 17, "t3_lat1_cycles");
        check("t3_lat1_carry", bus_b.carry_flag, 0);
        chk_reg(1, 2, 8'h0D, "t3_lat1_r2");
        chk_reg(1, 0, 8'h10, "t3_lat1_r0");

        // PC wrap with no halt: four increments of r0 in a 4-deep RAM
        for (int i = 0; i < 4; i++) load(1, i, enc(0, 1, 3'd0, 2'd0, 2'd0, 8'h01));
        pulse_start(1);
        check("t4_pc", bus_b.pc, 0);
        for (int i = 1; i <= 4; i++) begin
            repeat (5) tick();
            check("t4_pc", bus_b.pc, i % 4);
        end
        bus_b.dbg_sel = 2'd0;
        #1 check("t4_r0_after4", bus_b.dbg_data, 8'h14);
        repeat (20) tick();
        bus_b.dbg_sel = 2'd0;
        #1 check("t4_r0_after8", bus_b.dbg_data, 8'h18);

        // Asynchronous reset in the middle of an execute cycle
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mb.busy && mb.k == 2) found = 1'b1;
            else tick();
        end
        check("t1_reached_exec", found, 1);
        #1 rst = 1'b1;
        #1;
        check("t1_busy_b", bus_b.busy, 0);
        check("t1_done_a", bus_a.done, 0);
        check("t1_pc_b",   bus_b.pc,   0);
        check("t1_a_b",    bus_b.a,    0);
        check("t1_b_b",    bus_b.b,    0);
        check("t1_op_b",   bus_b.opcode, 0);
        for (int s = 0; s < 4; s++) begin
            bus_a.dbg_sel = 2'(s);
            bus_b.dbg_sel = 2'(s);
            #1;
            check("t1_dbg_a", bus_a.dbg_data, 0);
            check("t1_dbg_b", bus_b.dbg_data, 0);
        end
        tick();
        tick();
        rst = 1'b0;

        // Random programs with random load/start pokes, checked by the model
        for (int r = 0; r < 6; r++) begin
            which = r % 2;
            do_reset();
            for (int i = 0; i < ((which == 0) ? 16 : 4); i++) begin
                rv = $urandom;
                w = rv[17:0];
                w[17] = ($urandom_range(0, 7) == 0);
                load(which, i, w);
            end
            pulse_start(which);
            for (int i = 0; i < 150; i++) begin
                rv = $urandom;
                if (which == 0) begin
                    bus_a.prog_we = ($urandom_range(0, 15) == 0);
                    bus_a.prog_addr = rv[3:0];
                    bus_a.prog_wdata = rv[21:4];
                    bus_a.start = ($urandom_range(0, 15) == 0);
                end else begin
                    bus_b.prog_we = ($urandom_range(0, 15) == 0);
                    bus_b.prog_addr = rv[1:0];
                    bus_b.prog_wdata = rv[21:4];
                    bus_b.start = ($urandom_range(0, 15) == 0);
                end
                tick();
                bus_a.prog_we = 1'b0; bus_a.start = 1'b0;
                bus_b.prog_we = 1'b0; bus_b.start = 1'b0;
            end
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
